// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with registered result/flags, start/busy/done handshake,
// persistent carry for ADC/SBC, shift-add multiplier and undefined-opcode error.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       control,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_hi,
    output logic [3:0]       status,
    output logic             err
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOT  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SAR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_PASS = 5'd11;
    localparam logic [4:0] OP_CLR  = 5'd12;
    localparam logic [4:0] OP_ADC  = 5'd13;
    localparam logic [4:0] OP_SBC  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic [WIDTH-1:0]   ohi_q, ohi_d;
    logic [3:0]         status_q, status_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [SH_W-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0]   aluRes;
    logic               aluC, aluV, aluDef;
    logic               cin, bigAmt;
    logic [SH_W-1:0]    sh;
    logic [SH_W:0]      rotInv;
    logic [WIDTH:0]     addSum, subDiff;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] prodStep;

    // Single-cycle datapath; the carry-in is the flag value held when the op is accepted.
    always_comb begin
        sh      = a2[SH_W-1:0];
        bigAmt  = |a2[WIDTH-1:SH_W];
        rotInv  = (SH_W+1)'(WIDTH) - {1'b0, sh};
        cin     = (control == OP_ADC || control == OP_SBC) ? status_q[0] : 1'b0;
        addSum  = {1'b0, a1} + {1'b0, a2} + {{WIDTH{1'b0}}, cin};
        subDiff = {1'b0, a1} - {1'b0, a2} - {{WIDTH{1'b0}}, cin};
        aluRes  = '0;
        aluC    = status_q[0];
        aluV    = 1'b0;
        aluDef  = 1'b1;
        case (control)
            OP_ADD, OP_ADC: begin
                aluRes = addSum[WIDTH-1:0];
                aluC   = addSum[WIDTH];
                aluV   = (a1[WIDTH-1] == a2[WIDTH-1]) && (addSum[WIDTH-1] != a1[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                aluRes = subDiff[WIDTH-1:0];
                aluC   = subDiff[WIDTH];
                aluV   = (a1[WIDTH-1] != a2[WIDTH-1]) && (subDiff[WIDTH-1] != a1[WIDTH-1]);
            end
            OP_OR:   aluRes = a1 | a2;
            OP_AND:  aluRes = a1 & a2;
            OP_XOR:  aluRes = a1 ^ a2;
            OP_NOT:  aluRes = ~a2;
            OP_SHL:  aluRes = bigAmt ? '0 : (a1 << sh);
            OP_SHR:  aluRes = bigAmt ? '0 : (a1 >> sh);
            OP_SAR:  aluRes = bigAmt ? {WIDTH{a1[WIDTH-1]}} : $unsigned($signed(a1) >>> sh);
            OP_ROL:  aluRes = (a1 << sh) | (a1 >> rotInv);
            OP_ROR:  aluRes = (a1 >> sh) | (a1 << rotInv);
            OP_PASS: aluRes = a2;
            OP_CLR:  aluRes = '0;
            OP_MUL:  aluRes = '0;
            default: aluDef = 1'b0;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
    always_comb begin
        mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prodStep = {mulSum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        ohi_d    = ohi_q;
        status_d = status_q;
        err_d    = err_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done    = (state_q == S_DONE);
                state_d = S_IDLE;
                if (start) begin
                    if (control == OP_MUL) begin
                        mcand_d = a1;
                        prod_d  = {{WIDTH{1'b0}}, a2};
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DONE;
                        ohi_d   = '0;
                        if (aluDef) begin
                            o_d      = aluRes;
                            status_d = {aluV, aluRes[WIDTH-1], aluRes == '0, aluC};
                            err_d    = 1'b0;
                        end else begin
                            o_d   = '0;
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_MUL: begin
                busy   = 1'b1;
                prod_d = prodStep;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SH_W'(WIDTH-1)) begin
                    o_d      = prodStep[WIDTH-1:0];
                    ohi_d    = prodStep[2*WIDTH-1:WIDTH];
                    status_d = {1'b0, prodStep[WIDTH-1], prodStep[WIDTH-1:0] == '0,
                                prodStep[2*WIDTH-1:WIDTH] != '0};
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            o_q      <= '0;
            ohi_q    <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            o_q      <= o_d;
            ohi_q    <= ohi_d;
            status_q <= status_d;
            err_q    <= err_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o      = o_q;
    assign o_hi   = ohi_q;
    assign status = status_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): hand-computed results, flags, latency and handshake.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] control = 5'd0;
    logic [7:0] a1 = 8'h00;
    logic [7:0] a2 = 8'h00;
    logic       busy, done, err;
    logic [7:0] o, o_hi;
    logic [3:0] status;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .a1(a1), .a2(a2), .busy(busy), .done(done),
        .o(o), .o_hi(o_hi), .status(status), .err(err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called while the clock is low; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
        start   = 1'b1;
        control = op;
        a1      = x;
        a2      = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expLat);
        int n;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "/lat"}, n, expLat);
        @(negedge clk);
    endtask

    task automatic runVec(input string tag, input logic [4:0] op, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] expO, input logic [3:0] expS);
        applyStimulus(op, x, y);
        waitDone(tag, 1);
        checkOutput({tag, "/o"}, o, expO);
        checkOutput({tag, "/o_hi"}, o_hi, 8'h00);
        checkOutput({tag, "/status"}, status, expS);
        checkOutput({tag, "/err"}, err, 1'b0);
    endtask

    initial begin
        int n;
        int busyCnt;
        logic doneSeen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst/o", o, 8'h00);
        checkOutput("rst/o_hi", o_hi, 8'h00);
        checkOutput("rst/status", status, 4'h0);
        checkOutput("rst/err", err, 1'b0);
        checkOutput("rst/busy", busy, 1'b0);
        checkOutput("rst/done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Status is {V,N,Z,C}; each op below starts in the previous op's done cycle.
        runVec("add_ff_01",   5'd0,  8'hFF, 8'h01, 8'h00, 4'b0011);
        runVec("adc_carry",   5'd13, 8'h10, 8'h20, 8'h31, 4'b0000);
        runVec("add_ovf",     5'd0,  8'h7F, 8'h01, 8'h80, 4'b1100);
        runVec("sub_borrow",  5'd1,  8'h05, 8'h07, 8'hFE, 4'b0101);

        applyStimulus(5'd20, 8'h12, 8'h34);
        waitDone("undef", 1);
        checkOutput("undef/o", o, 8'h00);
        checkOutput("undef/o_hi", o_hi, 8'h00);
        checkOutput("undef/err", err, 1'b1);
        checkOutput("undef/status", status, 4'b0101);

        runVec("sbc_c1",      5'd14, 8'h10, 8'h00, 8'h0F, 4'b0000);

        applyStimulus(5'd15, 8'hFF, 8'hFF);
        n = 1;
        busyCnt = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy) busyCnt++;
            start   = 1'b1;
            control = 5'd0;
            a1      = 8'h00;
            a2      = 8'h00;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        checkOutput("mul/lat", n, 9);
        checkOutput("mul/busycycles", busyCnt, 8);
        @(negedge clk);
        checkOutput("mul/o", o, 8'h01);
        checkOutput("mul/o_hi", o_hi, 8'hFE);
        checkOutput("mul/status", status, 4'b0001);
        checkOutput("mul/err", err, 1'b0);

        runVec("sar_9",       5'd8,  8'h80, 8'd9,  8'hFF, 4'b0101);
        runVec("shl_8",       5'd6,  8'h81, 8'd8,  8'h00, 4'b0011);
        runVec("rol_1",       5'd9,  8'h81, 8'd1,  8'h03, 4'b0001);
        runVec("ror_9",       5'd10, 8'h81, 8'd9,  8'hC0, 4'b0101);
        runVec("rol_0",       5'd9,  8'h5A, 8'd0,  8'h5A, 4'b0001);
        runVec("shr_7",       5'd7,  8'h80, 8'd7,  8'h01, 4'b0001);
        runVec("sar_3",       5'd8,  8'h80, 8'd3,  8'hF0, 4'b0101);
        runVec("not",         5'd5,  8'h00, 8'h0F, 8'hF0, 4'b0101);
        runVec("xor",         5'd4,  8'hA5, 8'hFF, 8'h5A, 4'b0001);
        runVec("and",         5'd3,  8'hF0, 8'h3C, 8'h30, 4'b0001);
        runVec("or",          5'd2,  8'hF0, 8'h0F, 8'hFF, 4'b0101);
        runVec("pass",        5'd11, 8'h00, 8'h80, 8'h80, 4'b0101);
        runVec("clr",         5'd12, 8'h12, 8'h34, 8'h00, 4'b0011);
        runVec("shr_8",       5'd7,  8'h80, 8'd8,  8'h00, 4'b0011);
        runVec("add_80_80",   5'd0,  8'h80, 8'h80, 8'h00, 4'b1011);
        runVec("pass_a5",     5'd11, 8'h00, 8'hA5, 8'hA5, 4'b0101);

        applyStimulus(5'd15, 8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmul/o", o, 8'h00);
        checkOutput("rstmul/o_hi", o_hi, 8'h00);
        checkOutput("rstmul/status", status, 4'h0);
        checkOutput("rstmul/err", err, 1'b0);
        checkOutput("rstmul/busy", busy, 1'b0);
        checkOutput("rstmul/done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            doneSeen = doneSeen | done;
        end
        checkOutput("rstmul/nodone", doneSeen, 1'b0);

        runVec("add_after_rst", 5'd0, 8'h01, 8'h01, 8'h02, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("done/onepulse", done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the 8-bit datapath ALU: WIDTH-bit operands, registered result and flags, start/busy/done handshake.
- Adds a persistent carry for ADC/SBC, overflow/zero/negative flags, an iterative multiplier and error reporting for undefined opcodes.
- Sits between the register file and the writeback mux; the sequencer issues one operation at a time.

Parameters:
- WIDTH, 8, operand/result width; must be a power of two and at least 4.
- SH_W, $clog2(WIDTH), shift-amount bits used for rotate modulo.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  issue request; sampled at a clock edge only when busy=0
- control  input  5  opcode
- a1  input  WIDTH  operand 1
- a2  input  WIDTH  operand 2 / shift amount
- busy  output  1  high while a multi-cycle operation runs
- done  output  1  one-cycle pulse; o, o_hi, status and err are valid from this cycle on
- o  output  WIDTH  result (low half for MUL)
- o_hi  output  WIDTH  MUL high half; 0 for all other ops
- status  output  4  {V,N,Z,C}; C is status[0]
- err  output  1  undefined opcode; updated with every done

Behaviour:
- Reset (async, rst_n=0): o=0, o_hi=0, status=0, err=0, busy=0, done=0; the FSM goes to IDLE. Reset during MUL aborts it with no done pulse.
- FSM states:
  - IDLE: start=1 with a single-cycle op -> result registered at that edge, then DONE.
  - IDLE: start=1 with MUL -> latch operands, then MUL.
  - MUL: busy=1; one shift-add step per cycle for WIDTH cycles, then DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is accepted (back-to-back).
- start while busy=1 is ignored. Operands are latched at the accepting edge, so later changes to a1/a2 have no effect.
- Latency from the accepting edge to done high: single-cycle ops 1 cycle; MUL WIDTH+1 cycles.
- Opcodes:
  - 0 ADD: a1+a2
  - 1 SUB: a1-a2
  - 2 OR
  - 3 AND
  - 4 XOR
  - 5 NOT: ~a2
  - 6 SHL
  - 7 SHR (logical)
  - 8 SAR (arithmetic)
  - 9 ROL
  - 10 ROR
  - 11 PASS: a2
  - 12 CLR: o=0
  - 13 ADC: a1+a2+C
  - 14 SBC: a1-a2-C
  - 15 MUL: unsigned; {o_hi,o} = a1*a2
  - 16-31: undefined -> o=0, o_hi=0, err=1, status unchanged
- Shift rules: a2 is taken as an unsigned amount. For SHL/SHR, a2 >= WIDTH gives 0. For SAR, a2 >= WIDTH gives all bits equal to a1 sign. ROL/ROR use a2 mod WIDTH; amount 0 returns a1 unchanged.
- Flag rules:
  - Z = (o==0) and N = o[WIDTH-1] for every defined op.
  - C: ADD/ADC carry out of bit WIDTH-1. SUB/SBC borrow (1 when the true result is negative). MUL: C = (o_hi != 0). All other defined ops: C unchanged.
  - V: signed overflow for ADD/ADC/SUB/SBC; cleared for all other defined ops.
- ADC/SBC use the C value held at the accepting edge. A carry from the previous op is visible to an op started in that op's DONE cycle.
- The outputs o, o_hi, status and err are held between operations.

Test Plan:
- ADD 0xFF+0x01, then ADC 0x10+0x20 started in the DONE cycle -> first done: o=0x00, C=1, Z=1, V=0; second: o=0x31, C=0, Z=0.
- ADD 0x7F+0x01 -> o=0x80, V=1, N=1, C=0. SUB 0x05-0x07 -> o=0xFE, C=1, N=1, V=0. SBC 0x10-0x00 with C=1 -> o=0x0F.
- MUL 0xFF*0xFF -> busy for 8 cycles, done 9 cycles after the accepting edge, o=0x01, o_hi=0xFE, C=1. start pulses and a1/a2 changes during busy are ignored.
- Shifts:
  - SAR 0x80 by 9 -> 0xFF
  - SHL 0x81 by 8 -> 0x00, Z=1
  - ROL 0x81 by 1 -> 0x03
  - ROR 0x81 by 9 -> 0xC0
  - ROL 0x5A by 0 -> 0x5A
- rst_n low mid-MUL (cycle 4) -> all outputs 0 immediately; no done pulse. The next ADD 0x01+0x01 gives o=0x02 with C=0.
- Opcode 0x14 -> done after 1 cycle, o=0, err=1, status equal to the previous value. The next valid op clears err.
